// File: rtl/framebuffer_writer.sv
// framebuffer_writer: turns the painter's per-cycle pixel stream into writes on
// the back bank of a double-buffered framebuffer RAM and sequences frames
// (painter restart, drain, bank swap on vsync).
// Optional build macro: FB_OVERRUN_STATS_EN adds an 8-bit saturating count of
// vsync pulses that arrive while a frame is still being produced.
module framebuffer_writer #(
   parameter int COOR_WIDTH   = 12,
   parameter int H_RES        = 400,
   parameter int V_RES        = 300,
   parameter int TRANSPARENT  = 0,
   parameter int START_CYCLES = 2,
   parameter int ADDR_WIDTH   = $clog2(H_RES * V_RES) + 1
) (
   input  logic                  clk_33m,
   input  logic                  rst,
   input  logic                  vsync,
   input  logic [COOR_WIDTH-1:0] paint_x,
   input  logic [COOR_WIDTH-1:0] paint_y,
   input  logic [2:0]            paint_palette,
   input  logic                  paint_finished,
   output logic                  paint_rst,
   output logic                  fb_we,
   output logic [ADDR_WIDTH-1:0] fb_addr,
   output logic [2:0]            fb_data,
   output logic                  display_bank
`ifdef FB_OVERRUN_STATS_EN
   ,
   output logic [7:0]            overrun_count
`endif
);

   // Linear (in-bank) address width; the extra MSB of fb_addr is the bank.
   localparam int LIN_W   = ADDR_WIDTH - 1;
   // Shared counter covers both the START hold and the 2-cycle DRAIN.
   localparam int CNT_MAX = (START_CYCLES > 2) ? START_CYCLES : 2;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [COOR_WIDTH-1:0] X_LIM      = COOR_WIDTH'(H_RES);
   localparam logic [COOR_WIDTH-1:0] Y_LIM      = COOR_WIDTH'(V_RES);
   localparam logic [2:0]            TRANS_IDX  = 3'(TRANSPARENT);
   localparam logic [LIN_W-1:0]      H_RES_L    = LIN_W'(H_RES);
   localparam logic [CNT_W-1:0]      START_LAST = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_START,
      ST_PAINT,
      ST_DRAIN,
      ST_WAIT_VSYNC
   } state_t;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt;

   logic                    s1_valid;
   logic [COOR_WIDTH-1:0]   s1_x;
   logic [COOR_WIDTH-1:0]   s1_y;
   logic [2:0]              s1_palette;
   logic [LIN_W-1:0]        s1_lin;
   logic                    accept;

   // Stage-1 acceptance: painting, on screen, and not transparent.
   assign accept = (state == ST_PAINT) && (paint_x < X_LIM) &&
                   (paint_y < Y_LIM) && (paint_palette != TRANS_IDX);

   // Clipped coordinates always fit, so the product never exceeds LIN_W bits.
   assign s1_lin = LIN_W'(s1_y) * H_RES_L + LIN_W'(s1_x);

   // State register plus the per-state cycle counter (restarts on every transition).
   always_ff @(posedge clk_33m or negedge rst) begin
      if (!rst) begin
         state <= ST_START;
         cnt   <= '0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         state <= state_next;
         if (state_next != state) cnt <= '0;
         else                     cnt <= cnt + 1'b1;
      end
   end

   // Next-state and painter-reset decode; paint_finished only matters in PAINT.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_next = state;
      paint_rst  = 1'b0;
      case (state)
         ST_START: begin
            paint_rst = 1'b1;
            if (cnt == START_LAST) state_next = ST_PAINT;
         end
         ST_PAINT:      if (paint_finished)    state_next = ST_DRAIN;
         ST_DRAIN:      if (cnt == DRAIN_LAST) state_next = ST_WAIT_VSYNC;
         ST_WAIT_VSYNC: if (vsync)             state_next = ST_START;
         default:       state_next = ST_START;
      endcase
   end

   // Front/back bank swap, only between frames.
   always_ff @(posedge clk_33m or negedge rst) begin
      if (!rst)                                  display_bank <= 1'b0;
      else if (state == ST_WAIT_VSYNC && vsync) display_bank <= ~display_bank;
   end

   // Stage 1: register the accepted pixel.
   always_ff @(posedge clk_33m or negedge rst) begin
      if (!rst) begin
         s1_valid   <= 1'b0;
         s1_x       <= '0;
         s1_y       <= '0;
         s1_palette <= '0;
      end else begin
         s1_valid   <= accept;
         s1_x       <= paint_x;
         s1_y       <= paint_y;
         s1_palette <= paint_palette;
      end
   end

   // Stage 2: drive the RAM write port, always targeting the back bank.
   always_ff @(posedge clk_33m or negedge rst) begin
      if (!rst) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
      end else begin
         fb_we   <= s1_valid;
         fb_addr <= {~display_bank, s1_lin};
         fb_data <= s1_palette;
      end
   end

`ifdef FB_OVERRUN_STATS_EN
   // Saturating count of vsync pulses that arrive before the frame is ready.
   always_ff @(posedge clk_33m or negedge rst) begin
      if (!rst)
         overrun_count <= 8'd0;
      else if (vsync && state != ST_WAIT_VSYNC && overrun_count != 8'hFF)
         overrun_count <= overrun_count + 8'd1;
   end
`endif

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Sits directly downstream of the painter.
- Consumes the painter's per-cycle pixel stream (x, y, palette, finished) and turns it into write cycles on the double-buffered framebuffer RAM.
- Filters out transparent pixels, clips off-screen coordinates and computes linear addresses.
- Sequences frames: restarts the painter, waits for completion and swaps front/back banks on vsync.

Parameters:
- COOR_WIDTH, 12, width of painter x/y coordinates.
- H_RES, 400, framebuffer width in pixels.
- V_RES, 300, framebuffer height in pixels.
- TRANSPARENT, 0, palette index that is never written.
- START_CYCLES, 2, number of cycles paint_rst is held high per frame (minimum 1).
- ADDR_WIDTH, $clog2(H_RES*V_RES)+1, framebuffer address width; the MSB is the bank select.

Ports:
- clk_33m  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- vsync  input  1  one-cycle pulse from display timing at start of vertical blanking.
- paint_x  input  COOR_WIDTH  painter write x (unsigned; negative values arrive wrapped).
- paint_y  input  COOR_WIDTH  painter write y.
- paint_palette  input  3  painter palette index.
- paint_finished  input  1  painter done flag (sticky until painter reset).
- paint_rst  output  1  active-high reset to the painter.
- fb_we  output  1  framebuffer write enable.
- fb_addr  output  ADDR_WIDTH  {bank, y*H_RES+x}.
- fb_data  output  3  palette to write.
- display_bank  output  1  bank currently scanned out; the back bank is ~display_bank.

Behaviour:
- Reset (rst=0, async):
  - state=START, start counter=0, paint_rst=1, display_bank=0.
  - Pipeline valid bits=0, fb_we=0, fb_addr=0, fb_data=0.
- States:
  - START: paint_rst=1. Leave after START_CYCLES cycles → PAINT, with paint_rst=0 from the first PAINT cycle.
  - PAINT: pixels accepted. On a cycle with paint_finished=1, that cycle's pixel is still accepted → DRAIN.
  - DRAIN: 2 cycles, pipeline empties, no new pixels accepted → WAIT_VSYNC.
  - WAIT_VSYNC: on vsync=1, toggle display_bank → START.
- paint_finished is ignored outside PAINT. The painter's stale flag during START is masked.
- Pixel acceptance (stage 1, registered): s1_valid = (state==PAINT) && paint_x<H_RES && paint_y<V_RES && paint_palette!=TRANSPARENT. Register x, y, palette.
- Stage 2 (registered):
  - fb_we = s1_valid.
  - fb_addr = {~display_bank, y*H_RES+x}, computed at the full linear width with no truncation.
  - fb_data = palette.
- Latency: a pixel presented in cycle N appears on fb_we/fb_addr/fb_data in cycle N+2.
- No backpressure: the RAM port accepts one write every cycle.
- Repeated identical pixels from the painter's wait cycles are written again; this is harmless.
- Clipping: coordinates with the high bit set (wrapped negatives) are ≥ H_RES/V_RES and are therefore dropped. Boundary pixels x=H_RES-1 and y=V_RES-1 are written.
- Bank writes: only the back bank (~display_bank) is written. display_bank toggles only in WAIT_VSYNC on vsync, and never mid-frame.
- vsync in START, PAINT or DRAIN:
  - No swap, and not remembered.
  - The next swap requires a fresh vsync in WAIT_VSYNC.
  - Counted if FB_OVERRUN_STATS_EN is defined.
- Async reset mid-PAINT:
  - Writes stop immediately: fb_we=0 and pipeline bits cleared.
  - Painter is restarted via paint_rst=1.
  - display_bank returns to 0.

Optional Feature:
- Macro FB_OVERRUN_STATS_EN.
- Defined:
  - Adds output port overrun_count, 8 bits.
  - Resets to 0.
  - Increments by 1 on each vsync seen outside WAIT_VSYNC.
  - Saturates at 255.
- Undefined: no port and no counter; overrun vsyncs are silently ignored.

Test Plan:
- Reset, then PAINT with display_bank=0; present x=5, y=2, palette=3 in cycle N → in cycle N+2: fb_we=1, fb_addr={1,805}, fb_data=3.
- palette=0, and separately x=400,y=0 and x=0xFFF,y=10 → fb_we stays 0. x=399,y=299 is written at address {1,119999}.
- Release rst → paint_rst high exactly 2 cycles. Assert paint_finished; last pixel is still written; wait 2 DRAIN cycles; pulse vsync → display_bank=1 next cycle and paint_rst high again for 2 cycles. Next frame writes use bank bit 0.
- vsync pulse during PAINT → display_bank unchanged, overrun_count=1 (macro on); a later vsync in WAIT_VSYNC swaps normally.
- paint_finished held high from the previous frame during START → ignored; state reaches PAINT and pixels are written.
- Assert rst=0 mid-PAINT with a pixel in flight → fb_we=0 asynchronously, display_bank=0, paint_rst=1.
